// File: rtl/sram_burst_initiator_if.sv
// Handshake bundle between a burst requester and sram_burst_initiator.
//   cmd_*  : burst command (valid/ready), write flag, start address, beats-1
//   wr_*   : write data stream into the initiator (valid/ready)
//   rd_*   : read data stream out of the initiator (valid/ready)
// Modports: master = requester side, slave = initiator side.
interface sram_burst_initiator_if #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [BITS-1:0]       wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [BITS-1:0]       rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sram_burst_initiator.sv
// Burst initiator for one read/write port of a single-clock fakeram SRAM.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : cmd/wr/rd valid-ready streams (see sram_burst_initiator_if)
//   busy            : burst in progress
//   done            : 1-cycle pulse on the final beat of a burst
//   err             : 1-cycle pulse on a rejected burst (optional feature only)
//   mem_ce/mem_we   : SRAM chip/write enable, never X
//   mem_addr/mem_wd : SRAM address / write data, held between accesses
//   mem_rd          : SRAM read data, valid the cycle after a read access
// Optional feature macro: INITIATOR_WRAP_ERR_EN -- when defined, commands whose
// span runs past WORD_DEPTH-1 are accepted, then rejected with done+err and no
// SRAM access; otherwise such bursts wrap to address 0.
module sram_burst_initiator #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_burst_initiator_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BITS-1:0]       mem_wd,
  input  logic [BITS-1:0]       mem_rd
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, REJECT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_hold_q, addr_inc;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, pop_cnt_q;
  logic [BITS-1:0]       wd_hold_q;
  logic [BITS-1:0]       rsp_buf_q [2];
  logic                  wr_ptr_q, rd_ptr_q, inflight_q;
  logic [1:0]            fill_q;
  logic                  take_cmd, push, pop, issue_ok, access, write_access;
  logic                  cmd_rdy, wr_rdy, reject;
  logic [2:0]            credit_used;

  assign addr_inc = (addr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  // A read issued last cycle lands in the buffer this cycle. Counting the
  // current pop as a returned credit keeps 1 beat/clk with only two entries.
  assign push        = inflight_q;
  assign pop         = (fill_q != 2'd0) && bus.rd_ready;
  assign credit_used = {1'b0, fill_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok    = credit_used < 3'd2;

  assign bus.rd_valid  = (fill_q != 2'd0);
  assign bus.rd_data   = rsp_buf_q[rd_ptr_q];
  assign bus.cmd_ready = cmd_rdy & rst_n;
  assign bus.wr_ready  = wr_rdy;
  assign busy          = (state_q != IDLE);

`ifdef INITIATOR_WRAP_ERR_EN
  localparam int SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  logic [SUM_W-1:0] span_end;
  assign span_end = SUM_W'(bus.cmd_addr) + SUM_W'(bus.cmd_len);
  assign reject   = (span_end > SUM_W'(WORD_DEPTH - 1));
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_rdy      = 1'b0;
    wr_rdy       = 1'b0;
    take_cmd     = 1'b0;
    access       = 1'b0;
    write_access = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (bus.cmd_valid) begin
          take_cmd = 1'b1;
          if (reject)             state_d = REJECT;
          else if (bus.cmd_write) state_d = WRITE;
          else                    state_d = READ;
        end
      end
      WRITE: begin
        wr_rdy = 1'b1;
        if (bus.wr_valid) begin
          access       = 1'b1;
          write_access = 1'b1;
          if (beat_cnt_q == '0) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      READ: begin
        if (issue_ok) begin
          access = 1'b1;
          if (beat_cnt_q == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (pop_cnt_q == '0)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      REJECT: begin
        done = 1'b1;
`ifdef INITIATOR_WRAP_ERR_EN
        err  = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_ce   = access;
    mem_we   = write_access;
    mem_addr = access ? addr_q : addr_hold_q;
    mem_wd   = write_access ? bus.wr_data : wd_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      addr_hold_q  <= '0;
      beat_cnt_q   <= '0;
      pop_cnt_q    <= '0;
      wd_hold_q    <= '0;
      rsp_buf_q[0] <= '0;
      rsp_buf_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      inflight_q   <= 1'b0;
      fill_q       <= 2'd0;
    end else begin
      assert (!(push && !pop && (fill_q == 2'd2)));
      state_q    <= state_d;
      inflight_q <= access && !write_access;
      if (take_cmd) begin
        addr_q     <= bus.cmd_addr;
        beat_cnt_q <= bus.cmd_len;
        pop_cnt_q  <= bus.cmd_len;
      end else if (access) begin
        addr_q <= addr_inc;
        if (beat_cnt_q != '0) beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);
      end
      if (access)       addr_hold_q <= addr_q;
      if (write_access) wd_hold_q   <= bus.wr_data;
      if (push) begin
        rsp_buf_q[wr_ptr_q] <= mem_rd;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (pop_cnt_q != '0) pop_cnt_q <= pop_cnt_q - LEN_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 2'd1;
        2'b01:   fill_q <= fill_q - 2'd1;
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_initiator.sv
module tb_sram_burst_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        busy, done, err, mem_ce, mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wd;
  logic [63:0] mem_rd;
  logic [63:0] sram   [256];
  logic [63:0] shadow [256];
  int          checks = 0;
  int          failures = 0;

  sram_burst_initiator_if #(.BITS(64), .ADDR_WIDTH(8), .LEN_WIDTH(8)) bus ();

  sram_burst_initiator #(.BITS(64), .WORD_DEPTH(256), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done), .err(err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Behavioural fakeram: registered read, write on ce&we.
  always @(posedge clk) begin
    if (mem_ce === 1'b1) begin
      if (mem_we === 1'b1) sram[mem_addr] <= mem_wd;
      else                 mem_rd <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 0);
    chk({tag, ".wr_ready"},  64'(bus.wr_ready), 0);
    chk({tag, ".rd_valid"},  64'(bus.rd_valid), 0);
    chk({tag, ".rd_data"},   bus.rd_data, 0);
    chk({tag, ".busy"},      64'(busy), 0);
    chk({tag, ".done"},      64'(done), 0);
    chk({tag, ".err"},       64'(err), 0);
    chk({tag, ".mem_ce"},    64'(mem_ce), 0);
    chk({tag, ".mem_we"},    64'(mem_we), 0);
    chk({tag, ".mem_addr"},  64'(mem_addr), 0);
    chk({tag, ".mem_wd"},    mem_wd, 0);
  endtask

  function automatic logic [7:0] wrap_addr(input int base, input int off);
    return 8'((base + off) % 256);
  endfunction

  task automatic check_array(input string tag);
    for (int i = 0; i < 256; i++) chk(tag, sram[i], shadow[i]);
  endtask

  // One complete burst, checked cycle by cycle against the shadow memory.
  // wv_mode: 0 = wr_valid always 1, 1 = random.
  // rr_mode: 0 = rd_ready always 1, 1 = pattern 1,0,0, 2 = random.
  task automatic burst(input bit write, input int addr, input int len,
                       input logic [63:0] wdata [$], input int wv_mode, input int rr_mode);
    bit rej = 1'b0;
    bit finished = 1'b0;
    int k = 0, beats = 0, issued = 0, pops = 0;
    int budget = 4 * (len + 1) + 20;
`ifdef INITIATOR_WRAP_ERR_EN
    rej = (addr + len > 255);
`endif
    bus.cmd_valid = 1'b1;
    bus.cmd_write = write;
    bus.cmd_addr  = 8'(addr);
    bus.cmd_len   = 8'(len);
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    #2;
    chk("hs.cmd_ready", 64'(bus.cmd_ready), 1);
    chk("hs.busy", 64'(busy), 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_len   = 8'($urandom);
    while (!finished && k < budget) begin
      if (write) begin
        bus.wr_valid = (rej || wv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.wr_data  = (beats <= len) ? wdata[beats] : {$urandom, $urandom};
      end else begin
        case (rr_mode)
          0:       bus.rd_ready = 1'b1;
          1:       bus.rd_ready = (k % 3 == 0);
          default: bus.rd_ready = 1'($urandom_range(0, 1));
        endcase
      end
      #2;
      chk("b.cmd_ready", 64'(bus.cmd_ready), 0);
      chk("b.busy", 64'(busy), 1);
      if (rej) begin
        chk("rej.done", 64'(done), 1);
        chk("rej.err", 64'(err), 1);
        chk("rej.mem_ce", 64'(mem_ce), 0);
        chk("rej.wr_ready", 64'(bus.wr_ready), 0);
        finished = 1'b1;
      end else if (write) begin
        chk("w.wr_ready", 64'(bus.wr_ready), 1);
        chk("w.err", 64'(err), 0);
        chk("w.mem_ce", 64'(mem_ce), 64'(bus.wr_valid));
        chk("w.mem_we", 64'(mem_we), 64'(bus.wr_valid));
        if (bus.wr_valid) begin
          chk("w.mem_addr", 64'(mem_addr), 64'(wrap_addr(addr, beats)));
          chk("w.mem_wd", mem_wd, wdata[beats]);
          chk("w.done", 64'(done), 64'(beats == len));
          shadow[wrap_addr(addr, beats)] = wdata[beats];
          beats++;
          if (beats > len) finished = 1'b1;
        end else begin
          chk("w.done_idle", 64'(done), 0);
        end
      end else begin
        chk("r.mem_we", 64'(mem_we), 0);
        chk("r.err", 64'(err), 0);
        if (k < 2)  chk("r.early_valid", 64'(bus.rd_valid), 0);
        if (k == 2) chk("r.first_valid", 64'(bus.rd_valid), 1);
        if (mem_ce) begin
          chk("r.mem_addr", 64'(mem_addr), 64'(wrap_addr(addr, issued)));
          issued++;
          chk("r.over_issue", 64'(issued <= len + 1), 1);
        end
        if (bus.rd_valid && bus.rd_ready) begin
          chk("r.rd_data", bus.rd_data, shadow[wrap_addr(addr, pops)]);
          chk("r.done", 64'(done), 64'(pops == len));
          pops++;
          if (pops > len) finished = 1'b1;
        end else begin
          chk("r.done_idle", 64'(done), 0);
        end
        chk("r.ahead", 64'(issued - pops <= 2), 1);
        if (finished && rr_mode == 0) chk("r.throughput", 64'(k), 64'(len + 2));
      end
      @(negedge clk);
      k++;
    end
    chk("burst_finished", 64'(finished), 1);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    #2;
    chk("post.cmd_ready", 64'(bus.cmd_ready), 1);
    chk("post.busy", 64'(busy), 0);
    chk("post.mem_ce", 64'(mem_ce), 0);
    chk("post.rd_valid", 64'(bus.rd_valid), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] d [$];
    logic [63:0] none [$];
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #2 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #2 chk("rel.cmd_ready", 64'(bus.cmd_ready), 1);
    @(negedge clk);

    // Fill the whole array so every later read has a known expectation.
    d = {};
    for (int i = 0; i < 256; i++) d.push_back({$urandom, $urandom});
    burst(1'b1, 0, 255, d, 1, 0);

    // Test 1 / 2 / 3.
    d = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
    burst(1'b1, 'h10, 3, d, 0, 0);
    burst(1'b0, 'h10, 3, none, 0, 0);
    burst(1'b0, 'h10, 3, none, 0, 1);

    // Test 4: burst running off the top of the array.
    d = {64'h1111_0000_0000_00FE, 64'h2222_0000_0000_00FF, 64'h3333_0000_0000_0000};
    burst(1'b1, 'hFE, 2, d, 0, 0);
    burst(1'b0, 'hFE, 2, none, 0, 0);

    // Test 5: reset during the 3rd beat of an 8-beat read.
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h10; bus.cmd_len = 8'd7;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("rst5.pre_valid", 64'(bus.rd_valid), 1);
    rst_n = 1'b0;
    #1 check_all_zero("rst5");
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst5.cmd_ready", 64'(bus.cmd_ready), 1);
    chk("rst5.rd_valid", 64'(bus.rd_valid), 0);
    chk("rst5.busy", 64'(busy), 0);
    @(negedge clk);
    burst(1'b0, 'h30, 0, none, 0, 0);

    // Test 6: idle with garbage on data and command fields.
    for (int i = 0; i < 20; i++) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 8'($urandom);
      bus.cmd_len   = 8'($urandom);
      bus.wr_data   = {$urandom, $urandom};
      bus.wr_valid  = 1'($urandom);
      bus.rd_ready  = 1'($urandom);
      #2;
      chk("idle.mem_ce", 64'(mem_ce), 0);
      chk("idle.mem_we", 64'(mem_we), 0);
      chk("idle.wr_ready", 64'(bus.wr_ready), 0);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check_array("idle.array");

    // Randomised bursts.
    for (int n = 0; n < 16; n++) begin
      bit w = 1'($urandom_range(0, 1));
      int a = int'($urandom_range(0, 255));
      int l = int'($urandom_range(0, 11));
      d = {};
      for (int i = 0; i <= l; i++) d.push_back({$urandom, $urandom});
      burst(w, a, l, d, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    check_array("final.array");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_burst_initiator.md
Name: sram_burst_initiator

Overview:
Request-side controller that drives one read/write port of a single-clock fakeram SRAM macro. The default macro is 64 bits wide by 256 words deep.
- Accepts burst commands over a valid/ready interface.
- Streams write data into the SRAM and read data out with full backpressure.
- Absorbs the macro's fixed 1-cycle read latency with a 2-entry response buffer.
- Never presents X on the SRAM ce/we/addr pins, so the macro never corrupts its array.

Parameters:
BITS, 64, data word width
WORD_DEPTH, 256, SRAM depth in words
ADDR_WIDTH, 8, address width; must equal clog2(WORD_DEPTH)
LEN_WIDTH, 8, width of burst length field

Ports:
clk  input  1  single clock for the block and the attached SRAM port
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request valid
cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high
cmd_write  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_WIDTH  burst start word address
cmd_len  input  LEN_WIDTH  beats minus 1
wr_valid  input  1  write data beat valid
wr_ready  output  1  write beat consumed
wr_data  input  BITS  write data
rd_valid  output  1  read data beat valid
rd_ready  input  1  downstream accepts read beat
rd_data  output  BITS  read data
busy  output  1  burst in progress (state != IDLE)
done  output  1  1-cycle pulse when the last beat of a burst completes
err  output  1  1-cycle pulse; tied 0 unless the optional feature is compiled in
mem_ce  output  1  SRAM chip enable
mem_we  output  1  SRAM write enable
mem_addr  output  ADDR_WIDTH  SRAM address
mem_wd  output  BITS  SRAM write data
mem_rd  input  BITS  SRAM read data, valid the cycle after mem_ce=1 with mem_we=0

Behaviour:
Reset values:
- Async assert returns the block to IDLE; all outputs 0.
- mem_addr=0; response buffer empty; internal beat counter 0.

States:
- IDLE: cmd_ready=1.
  - On handshake, latch addr, len and write flag.
  - Go to WRITE if cmd_write=1, else READ.
- WRITE: wr_ready=1. On each wr_valid beat:
  - Same cycle: mem_ce=1, mem_we=1, mem_addr=current address, mem_wd=wr_data.
  - The address increments and the counter decrements.
  - On the beat where the counter is 0: done=1 in that cycle, next state IDLE.
- READ:
  - Issue mem_ce=1, mem_we=0 only when (buffer occupancy + in-flight reads) < 2.
  - The issue flag is registered. In the next cycle mem_rd is pushed into the buffer.
  - After the last read is issued, go to DRAIN.
- DRAIN: wait until the final beat has been popped (rd_valid & rd_ready), with done=1 in that pop cycle, then go to IDLE.

Response buffer:
- 2-entry FIFO; rd_valid = not empty; rd_data = head.
- Push and pop in the same cycle are both legal; occupancy is unchanged.
- Credit rule guarantees no overflow; an overflow is an assertion failure.
- Read throughput is 1 beat/clk when rd_ready is held high. First rd_valid appears 2 clks after the command handshake.

SRAM pin discipline:
- mem_ce=0 and mem_we=0 in every cycle without an access.
- mem_addr and mem_wd hold their last values between accesses.

Address arithmetic:
- Increment modulo WORD_DEPTH: address WORD_DEPTH-1 wraps to 0.
- Burst length = cmd_len+1 beats. cmd_len=0 is a single-beat burst.

Other rules:
- cmd_ready=0 in all states except IDLE; a new command is accepted no earlier than the cycle after done.
- Reset mid-burst: the burst is abandoned and buffer contents are discarded. mem_ce drops immediately (async). Any partial writes remain in the SRAM.

Optional Feature:
INITIATOR_WRAP_ERR_EN
- Defined: a command with cmd_addr+cmd_len > WORD_DEPTH-1 is accepted but rejected.
  - No SRAM access is made.
  - For writes, no wr beats are consumed.
  - done and err pulse together 1 cycle after the handshake, and the block returns to IDLE.
- Undefined: such bursts wrap silently to address 0; err is constant 0.

Test Plan:
1. Write burst addr=0x10, len=3, data 0xA0..0xA3 with wr_valid held high -> 4 consecutive cycles with mem_ce=1, mem_we=1, addr 0x10..0x13; done pulses on the 4th beat.
2. Read burst addr=0x10, len=3, rd_ready held high -> rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; first rd_valid 2 clks after the handshake; done on the last pop.
3. Same read with rd_ready toggling 1,0,0,1,... -> no beat lost or duplicated; mem_ce never issues more than 2 reads ahead of the pops; the output data order is unchanged.
4. Write addr=0xFE, len=2 -> SRAM accesses at 0xFE, 0xFF, 0x00. With INITIATOR_WRAP_ERR_EN: no mem_ce activity; done and err pulse together 1 clk after the handshake.
5. Deassert rst_n during the 3rd beat of an 8-beat read -> all outputs 0 in the same cycle; rd_valid=0; cmd_ready=1 after release; a following 1-beat read returns correct data.
6. Idle for 20 cycles with random X on wr_data and cmd fields while cmd_valid=0 -> mem_ce=0 and mem_we=0 throughout; the SRAM array is not corrupted.
